// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic stream: FSM encoding,
// default frame width and the bit-order convention common with the serial adder.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_HOLD  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = 5;

  // Serial words travel least-significant bit first.
  localparam bit LSB_FIRST = 1'b1;

  function automatic logic [CNT_W-1:0] last_index(input int width);
    return CNT_W'(width - 1);
  endfunction

endpackage

// File: rtl/serial_sum_deserializer_if.sv
// Serial sum/carry input and parallel valid/ready result port of the deserializer.
interface serial_sum_deserializer_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             sin_valid;
  logic             sin_first;
  logic             sin_bit;
  logic             sin_carry;
  logic [WIDTH:0]   out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             frame_err;

  modport master (
    output sin_valid, sin_first, sin_bit, sin_carry, out_ready,
    input  out_data, out_valid, busy, overrun, frame_err
  );

  modport slave (
    input  sin_valid, sin_first, sin_bit, sin_carry, out_ready,
    output out_data, out_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/serial_bit_counter.sv
// Loadable bit-position counter with a terminal-count flag at WIDTH-1;
// saturates there instead of wrapping.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          inc,
  output logic          tc
);
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (inc && !tc) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tc = (cnt_reg == CW'(last_index(WIDTH)));

endmodule

// File: rtl/serial_sum_deserializer.sv
// Collects LSB-first serial sum bits plus the final carry and presents the
// (WIDTH+1)-bit result {carry, sum} on a valid/ready port.
module serial_sum_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_sum_deserializer_if.slave bus
);
  state_t           state_reg;
  logic [WIDTH-1:0] sh_reg;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH:0]   out_data_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic             overrun_reg;
  logic             frame_err_reg;

  logic             take_first;
  logic             take_bit;
  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val;
  logic             cnt_inc;
  logic             cnt_tc;

  assign take_first = bus.sin_valid && bus.sin_first;
  assign take_bit   = bus.sin_valid && !bus.sin_first;

  // New bits enter at the end that ends up most significant, so after
  // WIDTH samples the first bit lands in bit 0.
  genvar gi;
  generate
    if (LSB_FIRST) begin : g_lsb
      assign first_word = {bus.sin_bit, {(WIDTH-1){1'b0}}};
      for (gi = 0; gi < WIDTH; gi++) begin : g_sh
        if (gi == WIDTH-1) begin : g_top
          assign sh_next[gi] = bus.sin_bit;
        end else begin : g_mid
          assign sh_next[gi] = sh_reg[gi+1];
        end
      end
    end else begin : g_msb
      assign first_word = {{(WIDTH-1){1'b0}}, bus.sin_bit};
      for (gi = 0; gi < WIDTH; gi++) begin : g_sh
        if (gi == 0) begin : g_bot
          assign sh_next[gi] = bus.sin_bit;
        end else begin : g_mid
          assign sh_next[gi] = sh_reg[gi-1];
        end
      end
    end
  endgenerate

  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (take_first) begin
          cnt_load     = 1'b1;
          cnt_load_val = CW'(1);
        end
      end
      S_SHIFT: begin
        if (take_first) begin
          cnt_load     = 1'b1;
          cnt_load_val = CW'(1);
        end else if (take_bit) begin
          if (cnt_tc) cnt_load = 1'b1;
          else        cnt_inc  = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.out_ready && take_first) begin
          cnt_load     = 1'b1;
          cnt_load_val = CW'(1);
        end
      end
      default: cnt_load = 1'b1;
    endcase
  end

  serial_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      sh_reg        <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (take_first) begin
            sh_reg    <= first_word;
            busy_reg  <= 1'b1;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (take_first) begin
            sh_reg        <= first_word;
            frame_err_reg <= 1'b1;
          end else if (take_bit) begin
            sh_reg <= sh_next;
            if (cnt_tc) begin
              out_data_reg  <= {bus.sin_carry, sh_next};
              out_valid_reg <= 1'b1;
              busy_reg      <= 1'b0;
              state_reg     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (take_first) begin
              sh_reg    <= first_word;
              busy_reg  <= 1'b1;
              state_reg <= S_SHIFT;
            end else begin
              state_reg <= S_IDLE;
            end
          end else if (bus.sin_valid) begin
            overrun_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          sh_reg        <= '0;
          out_data_reg  <= '0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          overrun_reg   <= 1'b0;
          frame_err_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Directed plus randomized stimulus against a queue-based frame model of the
// serial sum deserializer.
module tb_serial_sum_deserializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_sum_deserializer_if #(.WIDTH(W)) bus ();

  serial_sum_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: bits gathered so far, plus the held result.
  int bq[$];
  bit m_collect = 1'b0;
  bit m_hold    = 1'b0;
  bit m_ovr     = 1'b0;
  bit m_ferr    = 1'b0;
  int m_data    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit f, input bit b,
                            input bit c, input bit rdy);
    m_ferr = 1'b0;
    if (r) begin
      bq.delete();
      m_collect = 1'b0;
      m_hold    = 1'b0;
      m_ovr     = 1'b0;
      m_data    = 0;
    end else if (m_hold) begin
      if (rdy) begin
        m_hold = 1'b0;
        if (v && f) begin
          bq.delete();
          bq.push_back(int'(b));
          m_collect = 1'b1;
        end
      end else if (v) begin
        m_ovr = 1'b1;
      end
    end else if (m_collect) begin
      if (v) begin
        if (f) begin
          m_ferr = 1'b1;
          bq.delete();
        end
        bq.push_back(int'(b));
        if (bq.size() == W) begin
          m_data = int'(c) * (1 << W);
          foreach (bq[i]) m_data += bq[i] * (1 << i);
          m_hold    = 1'b1;
          m_collect = 1'b0;
          bq.delete();
        end
      end
    end else if (v && f) begin
      bq.delete();
      bq.push_back(int'(b));
      m_collect = 1'b1;
    end
  endtask

  task automatic cycle(input bit r, input bit v, input bit f, input bit b,
                       input bit c, input bit rdy);
    rst           = r;
    bus.sin_valid = v;
    bus.sin_first = f;
    bus.sin_bit   = b;
    bus.sin_carry = c;
    bus.out_ready = rdy;
    if (!r && bus.out_valid && rdy)
      $display("xfer out_data=%b t=%0t", bus.out_data, $time);
    model_step(r, v, f, b, c, rdy);
    @(posedge clk);
    #1;
    chk("out_valid", bus.out_valid, m_hold);
    chk("out_data",  bus.out_data,  m_data);
    chk("busy",      bus.busy,      m_collect);
    chk("overrun",   bus.overrun,   m_ovr);
    chk("frame_err", bus.frame_err, m_ferr);
  endtask

  task automatic send(input logic [W-1:0] val, input bit c, input bit rdy);
    for (int i = 0; i < W; i++)
      cycle(1'b0, 1'b1, i == 0, val[i], (i == W-1) ? c : 1'($urandom_range(1)), rdy);
  endtask

  initial begin
    bus.sin_valid = 1'b0;
    bus.sin_first = 1'b0;
    bus.sin_bit   = 1'b0;
    bus.sin_carry = 1'b0;
    bus.out_ready = 1'b0;

    // Reset with random inputs
    repeat (2) cycle(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    chk("rst_data", bus.out_data, 0);
    chk("rst_valid", bus.out_valid, 0);

    // Reset mid-frame discards the partial frame
    cycle(0, 1, 1, 1, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 1, 1, 1);
    cycle(0, 1, 0, 1, 1, 1);
    chk("midrst_valid", bus.out_valid, 0);
    send(4'b0110, 1'b1, 1'b0);
    chk("post_rst_frame", bus.out_data, 5'b10110);
    cycle(0, 0, 0, 0, 0, 1);

    // Basic 5+6=11
    send(4'b1011, 1'b0, 1'b1);
    chk("basic_data", bus.out_data, 5'b01011);
    chk("basic_valid", bus.out_valid, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("basic_pulse", bus.out_valid, 0);

    // 9+8=17 with a 3-cycle stall between bits 2 and 3
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    repeat (3) begin
      cycle(0, 0, 0, 1, 1, 0);
      chk("stall_busy", bus.busy, 1);
    end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0);
    chk("carry_data", bus.out_data, 5'b10001);

    // Back-pressure then back-to-back frame
    repeat (4) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data", bus.out_data, 5'b10001);
    end
    cycle(0, 1, 1, 0, 0, 1);
    chk("b2b_busy", bus.busy, 1);
    cycle(0, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 1, 0, 0);
    chk("b2b_data", bus.out_data, 5'b01110);
    cycle(0, 0, 0, 0, 0, 1);

    // Abort on the third bit, new frame 1,0,1,0
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 1, 0, 1, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    chk("abort_ferr", bus.frame_err, 1);
    cycle(0, 1, 0, 0, 0, 0);
    chk("abort_ferr_end", bus.frame_err, 0);
    cycle(0, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    chk("abort_data", bus.out_data, 5'b00101);

    // Overrun while holding
    cycle(0, 1, 0, 1, 1, 0);
    chk("ovr_set", bus.overrun, 1);
    chk("ovr_data", bus.out_data, 5'b00101);
    cycle(0, 0, 0, 0, 0, 1);
    send(4'(($urandom_range(15))), 1'($urandom_range(1)), 1'b1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("ovr_sticky", bus.overrun, 1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      bit r, v, f;
      r = ($urandom_range(99) == 0);
      v = ($urandom_range(9) < 7);
      f = m_collect ? ($urandom_range(15) == 0) : ($urandom_range(1) == 0);
      cycle(r, v, f, 1'($urandom_range(1)), 1'($urandom_range(1)),
            ($urandom_range(9) < 6));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_sum_deserializer.md
Name: serial_sum_deserializer

Overview:
Receiving end of the team's LSB-first bit-serial arithmetic stream. It collects the serial sum bits and the final carry produced by the bit-serial adder datapath, and reassembles them into a parallel (WIDTH+1)-bit result. The result is presented on a valid/ready output port. It sits between the serial adder's sum/carry outputs and any parallel consumer (display, register file, bus).

Parameters:
WIDTH, 4, number of sum bits per frame; legal range 2..16.
CW, 5, counter width; constant fixed to 5, so the counter holds up to WIDTH=16.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
sin_valid  input  1  serial bit qualifier; bit sampled only when high
sin_first  input  1  marks the LSB (first bit) of a frame; meaningful only with sin_valid
sin_bit  input  1  serial sum bit, LSB first
sin_carry  input  1  final carry; sampled only together with the WIDTH-th (last) bit
out_data  output  WIDTH+1  {carry, sum[WIDTH-1:0]}
out_valid  output  1  out_data holds a complete frame
out_ready  input  1  consumer accepts out_data
busy  output  1  frame collection in progress
overrun  output  1  sticky: a bit was dropped while a result was held; cleared only by rst
frame_err  output  1  one-cycle pulse: a frame was aborted by an early sin_first

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. rst is synchronous and active-high, and has priority over every other input.
- Reset values: out_data=0, out_valid=0, busy=0, overrun=0, frame_err=0. State=IDLE, bit counter=0, shift register=0.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - sin_valid && sin_first: sample sin_bit into the shift register, cnt=1, go to SHIFT, busy=1.
  - sin_valid without sin_first: bit ignored, no flag raised.
- SHIFT:
  - Each sample shifts right with the new bit entering at the MSB (bit WIDTH-1). After WIDTH samples, the first bit sits at bit 0.
  - sin_valid low: stall. Register and counter hold, no timeout.
  - sin_valid && sin_first before WIDTH bits are collected: abort the frame. frame_err=1 for that cycle. Treat the bit as bit 0 of a new frame, cnt=1.
  - On the WIDTH-th sample (cnt==WIDTH-1 && sin_valid && !sin_first):
    - out_data <= {sin_carry, assembled word}
    - out_valid=1 from the next cycle; latency is 1 cycle after the last bit
    - busy=0, go to HOLD.
- HOLD:
  - out_valid stays 1 and out_data stays stable until out_ready.
  - out_ready=1: out_valid=0 next cycle, go to IDLE.
  - out_ready=1 with sin_valid && sin_first in the same cycle: the handshake completes and the bit is accepted as bit 0 of the next frame. Go directly to SHIFT with cnt=1, so back-to-back frames lose no cycle.
  - sin_valid=1 in any HOLD cycle without a completing handshake: the bit is dropped and overrun<=1 (sticky).
- out_data changes only on frame completion. It is not cleared when consumed.
- Counter never wraps past WIDTH-1. Illegal state encodings return to IDLE with outputs at reset values.
- rst mid-frame or in HOLD: the partial frame or held result is discarded and all outputs return to reset values on the next edge.

Decomposition:
- Shared package serial_pkg:
  - state encoding constants S_IDLE=2'b00, S_SHIFT=2'b01, S_HOLD=2'b10
  - default WIDTH=4
  - the LSB-first bit-order convention, common with the serial adder.
- Sub-module serial_bit_counter:
  - loadable up-counter with a terminal-count flag (cnt==WIDTH-1)
  - reusable by the serial adder control FSM.
- The shift register and FSM stay in the top module.

Test Plan:
- Reset: drive rst for 2 cycles with random inputs -> all outputs 0. rst mid-frame after 2 bits -> out_valid stays 0. A full frame sent afterwards assembles correctly.
- Basic frame, 5+6=11 (WIDTH=4): bits 1,1,0,1 with first on bit 1, carry 0 on bit 4, out_ready=1 -> one cycle later out_data=5'b01011, out_valid=1 for exactly 1 cycle.
- Carry and stalls, 9+8=17: bits 1,0,0,0 with carry 1; drop sin_valid for 3 cycles between bits 2 and 3 -> out_data=5'b10001. busy=1 throughout the collection, including the stall cycles.
- Back-pressure and back-to-back:
  - hold out_ready=0 for 4 cycles after completion -> out_data stays stable and out_valid stays 1.
  - then assert out_ready together with sin_first of the next frame (bits 0,1,1,1, carry 0) -> second out_data=5'b01110, with no gap cycle.
- Abort: sin_first reasserted on the 3rd bit -> frame_err pulses for 1 cycle. The new frame 1,0,1,0 (carry 0) completes with out_data=5'b00101.
- Overrun: in HOLD with out_ready=0, send one sin_valid bit -> overrun=1 and out_data unchanged. overrun stays set through subsequent frames until rst.
